s_inst_issue: RTL
=================

S_INST_ISSUE -- requirements
Module: s_inst_issue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; its ports SHALL be exactly REQ-002 to REQ-016.
REQ-002 clock  in  1  sole clock, rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  begin fetching at start_pc; sampled only in IDLE/DONE.
REQ-005 start_pc  in  32  byte address of the first instruction.
REQ-006 imem_req  out  1  single-cycle instruction-memory read request.
REQ-007 imem_addr  out  32  read byte address; valid while imem_req=1.
REQ-008 imem_rdata  in  32  read data; valid while imem_rvalid=1.
REQ-009 imem_rvalid  in  1  read response, at least 1 cycle after its request.
REQ-010 redirect  in  1  branch taken by the scalar ALU; redirect_pc is the new fetch address.
REQ-011 redirect_pc  in  32  redirect target byte address.
REQ-012 inst_valid / inst_ready  out / in  1 / 1  issue handshake to the scalar ALU.
REQ-013 inst_word  out  32  instruction dword.
REQ-014 inst_literal, inst_has_lit  out  32, 1  trailing literal constant and its flag.
REQ-015 inst_pc  out  32  byte address of inst_word.
REQ-016 issued_count, busy  out  16, 1  issued-instruction counter; busy=1 when the state is neither IDLE nor DONE.

Function
REQ-017 The state machine SHALL have the states IDLE, REQ0, WAIT0, REQ1, WAIT1, ISSUE, DRAIN and DONE.
REQ-018 Fetch start: in IDLE or DONE with start=1 -> pc<=start_pc, state REQ0; start in any other state SHALL be ignored.
REQ-019 REQ0: imem_req=1, imem_addr=pc -> WAIT0. REQ1: imem_req=1, imem_addr=pc+4 -> WAIT1. imem_req SHALL be 0 in every other state.
REQ-020 At most one memory request SHALL be outstanding; an imem_rvalid outside WAIT0/WAIT1/DRAIN SHALL be ignored.
REQ-021 WAIT0 with imem_rvalid: inst_word<=imem_rdata; go to REQ1 if a literal is needed, otherwise clear inst_has_lit and go to ISSUE.
REQ-022 WAIT1 with imem_rvalid: inst_literal<=imem_rdata, inst_has_lit<=1 -> ISSUE.
REQ-023 Literal-needed decode (on imem_rdata):
- SOP1 ([31:23]=9'h17D) with [7:0]=8'hFF;
- SOPC ([31:23]=9'h17E) or SOP2 ([31:30]=2'b10, [29:28]!=2'b11) with [7:0]=8'hFF or [15:8]=8'hFF;
- SOPK, SOPP and all other encodings: no literal.
REQ-024 ISSUE: inst_valid=(state==ISSUE)&&!redirect; inst_word/literal/has_lit/pc SHALL hold stable until the transfer.
REQ-025 Transfer = inst_valid&&inst_ready: pc<=pc+(has_lit?8:4), issued_count<=issued_count+1 (wraps 0xFFFF->0), next state REQ0, or DONE if inst_word is S_ENDPGM ([31:23]=9'h17F, [22:16]=7'd1).
REQ-026 inst_pc SHALL equal the pc value at which inst_word was fetched.
REQ-027 Redirect in REQ0..ISSUE SHALL have priority over all other events: pc<=redirect_pc and inst_has_lit<=0, then the next state is:
- WAIT0/WAIT1 with imem_rvalid in the same cycle: response dropped -> REQ0;
- REQ0/REQ1, or WAIT0/WAIT1 without imem_rvalid: DRAIN;
- ISSUE: no transfer, no count increment -> REQ0.
REQ-028 DRAIN: the next imem_rvalid SHALL be dropped -> REQ0; a further redirect in DRAIN only updates pc.
REQ-029 Redirect in IDLE, DONE or DRAIN SHALL NOT change state.
REQ-030 pc arithmetic SHALL be 32-bit modulo 2^32.

Reset
REQ-031 While reset_n=0: state IDLE; pc, inst_word, inst_literal, inst_pc and issued_count 0; inst_has_lit, inst_valid, imem_req and busy 0.
REQ-032 Reset asserted mid-operation SHALL abandon any outstanding request; a response arriving afterwards in IDLE SHALL be ignored.

Verification
REQ-033 start_pc=0x100; rdata 0xBE800080 two cycles after req -> req at 0x100, issue word 0xBE800080, has_lit=0, inst_pc=0x100; next req at 0x104; issued_count=1.
REQ-034 Words 0xBE8000FF then 0xDEADBEEF at 0x100/0x104 -> reqs at 0x100 and 0x104; issue has_lit=1, literal 0xDEADBEEF; next req at 0x108. Repeat with SOP2 0x8000FF01 -> same literal behaviour.
REQ-035 inst_ready=0 for 5 cycles in ISSUE -> inst_valid held at 1, outputs stable, no imem_req, count unchanged; transfer on the 6th cycle.
REQ-036 redirect to 0x200 in WAIT0 (no rvalid) -> DRAIN; the stale rvalid is dropped and nothing issues; next req at 0x200. redirect in ISSUE with inst_ready=1 -> inst_valid=0, count unchanged.
REQ-037 0xBF810000 fetched -> issued, then DONE, no further imem_req, busy=0; start with start_pc=0x40 -> req at 0x40.
REQ-038 reset_n pulsed low while in WAIT1 -> all outputs 0, state IDLE; the late rvalid is ignored.

Source files
------------

// File: rtl/s_inst_issue.sv
// s_inst_issue: scalar instruction fetch and issue sequencer.
// Fetches one instruction dword from instruction memory, plus a trailing
// literal dword when the encoding calls for one. It then presents the result
// to the scalar ALU with a valid/ready handshake. Only one memory request is
// ever outstanding. A taken branch (redirect) retargets the fetch pc. Any
// response still in flight is discarded through the DRAIN state.
//
// Ports:
//   clock, reset_n            clock (rising edge), async active-low reset
//   start, start_pc           begin fetching at start_pc (IDLE/DONE only)
//   imem_req, imem_addr       single-cycle read request and byte address
//   imem_rdata, imem_rvalid   read response
//   redirect, redirect_pc     branch taken by the scalar ALU, new fetch pc
//   inst_valid, inst_ready    issue handshake
//   inst_word, inst_pc        instruction dword and its byte address
//   inst_literal, inst_has_lit trailing literal and its flag
//   issued_count, busy        transfer counter, state neither IDLE nor DONE
module s_inst_issue (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] start_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [31:0] inst_literal,
  output logic        inst_has_lit,
  output logic [31:0] inst_pc,
  output logic [15:0] issued_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, REQ0, WAIT0, REQ1, WAIT1, ISSUE, DRAIN, DONE
  } state_t;

  state_t      state;
  logic [31:0] pc;

  // A literal follows SOP1 when src0 selects it (0xFF). It follows SOPC
  // and SOP2 when either source field does. SOP2 excludes [29:28]=11,
  // which keeps SOP1/SOPC/SOPK/SOPP out of its match.
  function automatic logic needs_literal(input logic [31:0] w);
    logic sop1, sopc, sop2;
    sop1 = (w[31:23] == 9'h17D);
    sopc = (w[31:23] == 9'h17E);
    sop2 = (w[31:30] == 2'b10) && (w[29:28] != 2'b11);
    return (sop1 && (w[7:0] == 8'hFF)) ||
           ((sopc || sop2) && ((w[7:0] == 8'hFF) || (w[15:8] == 8'hFF)));
  endfunction

  function automatic logic is_endpgm(input logic [31:0] w);
    return (w[31:23] == 9'h17F) && (w[22:16] == 7'd1);
  endfunction

  assign imem_req   = (state == REQ0) || (state == REQ1);
  assign imem_addr  = (state == REQ1) ? pc + 32'd4 : pc;
  assign inst_valid = (state == ISSUE) && !redirect;
  assign busy       = (state != IDLE) && (state != DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pc           <= '0;
      inst_word    <= '0;
      inst_literal <= '0;
      inst_has_lit <= 1'b0;
      inst_pc      <= '0;
      issued_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pc    <= start_pc;
            state <= REQ0;
          end
        end
        REQ0, REQ1: begin
          if (redirect) begin
            // The request went out this cycle, so its response must be drained.
            pc           <= redirect_pc;
            inst_has_lit <= 1'b0;
            state        <= DRAIN;
          end else begin
            state <= (state == REQ0) ? WAIT0 : WAIT1;
          end
        end
        WAIT0, WAIT1: begin
          if (redirect) begin
            pc           <= redirect_pc;
            inst_has_lit <= 1'b0;
            state        <= imem_rvalid ? REQ0 : DRAIN;
          end else if (imem_rvalid) begin
            if (state == WAIT0) begin
              inst_word <= imem_rdata;
              inst_pc   <= pc;
              if (needs_literal(imem_rdata)) begin
                state <= REQ1;
              end else begin
                inst_has_lit <= 1'b0;
                state        <= ISSUE;
              end
            end else begin
              inst_literal <= imem_rdata;
              inst_has_lit <= 1'b1;
              state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (redirect) begin
            pc           <= redirect_pc;
            inst_has_lit <= 1'b0;
            state        <= REQ0;
          end else if (inst_ready) begin
            pc           <= pc + (inst_has_lit ? 32'd8 : 32'd4);
            issued_count <= issued_count + 16'd1;
            state        <= is_endpgm(inst_word) ? DONE : REQ0;
          end
        end
        DRAIN: begin
          if (redirect) pc <= redirect_pc;
          if (imem_rvalid) state <= REQ0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
